// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite subordinate mapping reads/writes onto NUM_REGS registers exported on regs_out.
// Define AXI4_LITE_REG_BANK_ID_EN to make register 0 a read-only ID_VALUE register.
module axi4_lite_reg_bank #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter logic [31:0] ID_VALUE   = 32'h0000_B15C
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_WIDTH-1:0]          rdata,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [2:0]                     bresp,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int unsigned OFFS_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned HI_LSB = OFFS_W + IDX_W;
    localparam logic [2:0]  RESP_OKAY   = 3'b000;
    localparam logic [2:0]  RESP_SLVERR = 3'b010;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    r_state_t              r_state_q, r_state_d;
    w_state_t              w_state_q, w_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [2:0]            bresp_q, bresp_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> HI_LSB) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[OFFS_W +: IDX_W];
    endfunction

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
`ifdef AXI4_LITE_REG_BANK_ID_EN
        return in_range(a) && (word_idx(a) != '0);
`else
        return in_range(a);
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] slot_value(input logic [IDX_W-1:0] i,
                                                         input logic [DATA_WIDTH-1:0] v);
`ifdef AXI4_LITE_REG_BANK_ID_EN
        return (i == '0) ? DATA_WIDTH'(ID_VALUE) : v;
`else
        return (i == '0) ? v : v;
`endif
    endfunction

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;

        // Reads sample regs_q, so a read captured on a commit edge sees the old value.
        case (r_state_q)
            R_IDLE: if (arvalid && arready_q) begin
                rdata_d   = in_range(araddr)
                          ? slot_value(word_idx(araddr), regs_q[word_idx(araddr)]) : '0;
                r_state_d = R_DATA;
            end
            R_DATA: if (rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase

        case (w_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    if (writable(awaddr_q)) begin
                        regs_d[word_idx(awaddr_q)] = wdata_q;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                    w_state_d = W_RESP;
                end else begin
                    if (awvalid && awready_q) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = awaddr;
                    end
                    if (wvalid && wready_q) begin
                        w_held_d = 1'b1;
                        wdata_d  = wdata;
                    end
                end
            end
            W_RESP: if (bready) begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            regs_q    <= '{default: '0};
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            regs_q    <= regs_d;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_WIDTH +: DATA_WIDTH] = slot_value(IDX_W'(i), regs_q[i]);
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Scoreboard bench for axi4_lite_reg_bank: driver pushes expected responses, monitors pop on handshakes.
// Honours AXI4_LITE_REG_BANK_ID_EN the same way as the design.
module tb_axi4_lite_reg_bank;

    localparam int NREGS = 8;
    localparam logic [31:0] ID_VAL = 32'h0000_B15C;
`ifdef AXI4_LITE_REG_BANK_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  araddr, rdata;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0]  awaddr, wdata;
    logic [2:0]   bresp;
    logic [255:0] regs_out;

    axi4_lite_reg_bank #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREGS), .ID_VALUE(ID_VAL)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .regs_out(regs_out)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [NREGS];
    logic [31:0] rq [$];
    logic [2:0]  bq [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: byte address -> word, in range below NREGS*4 bytes.
    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a >= NREGS * 4) return 32'h0;
        if (ID_EN && (a / 4) == 0) return ID_VAL;
        return model[a / 4];
    endfunction

    function automatic logic [2:0] model_write(input logic [31:0] a, input logic [31:0] d);
        if (a >= NREGS * 4 || (ID_EN && (a / 4) == 0)) return 3'b010;
        model[a / 4] = d;
        return 3'b000;
    endfunction

    function automatic logic [255:0] model_packed();
        logic [255:0] p = '0;
        for (int i = 0; i < NREGS; i++)
            p[i*32 +: 32] = (ID_EN && i == 0) ? ID_VAL : model[i];
        return p;
    endfunction

    always @(negedge aclk) begin
        if (rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", 1, 0);
            else chk("rdata", rdata, rq.pop_front());
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", bresp, bq.pop_front());
        end
    end

    // which: 0 AR, 1 AW, 2 W, 3 AW and W together. Returns at posedge+1 after the handshake.
    task automatic wait_ready(input string name, input int which);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge aclk);
            case (which)
                0: ok = arready;
                1: ok = awready;
                2: ok = wready;
                default: ok = awready && wready;
            endcase
        end
        chk({name, "_handshake"}, ok, 1);
        @(posedge aclk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input int rdelay);
        logic [31:0] e = exp_read(a);
        rq.push_back(e);
        arvalid = 1'b1; araddr = a;
        wait_ready("ar", 0);
        arvalid = 1'b0;
        @(negedge aclk);
        chk("r_latency", rvalid, 1);
        chk("r_arready_busy", arready, 0);
        for (int i = 0; i < rdelay; i++) begin
            @(negedge aclk);
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_data", rdata, e);
            chk("r_hold_arready", arready, 0);
        end
        @(posedge aclk); #1 rready = 1'b1;
        @(posedge aclk); #1 rready = 1'b0;
        @(negedge aclk);
        chk("r_idle_ready", {arready, rvalid}, 2'b10);
        @(posedge aclk); #1;
    endtask

    // order: 0 same cycle, 1 AW then W, 2 W then AW; gap idle cycles between channels.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int order,
                            input int gap, input int bdelay);
        logic [2:0] e = model_write(a, d);
        bq.push_back(e);
        if (order == 0) begin
            awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d;
            wait_ready("aww", 3);
            awvalid = 1'b0; wvalid = 1'b0;
        end else begin
            if (order == 1) begin
                awvalid = 1'b1; awaddr = a;
                wait_ready("aw", 1);
                awvalid = 1'b0;
            end else begin
                wvalid = 1'b1; wdata = d;
                wait_ready("w", 2);
                wvalid = 1'b0;
            end
            for (int i = 0; i < gap; i++) begin
                @(negedge aclk);
                chk("w_half_readies", {awready, wready, bvalid}, (order == 1) ? 3'b010 : 3'b100);
                @(posedge aclk); #1;
            end
            if (order == 1) begin
                wvalid = 1'b1; wdata = d;
                wait_ready("w", 2);
                wvalid = 1'b0;
            end else begin
                awvalid = 1'b1; awaddr = a;
                wait_ready("aw", 1);
                awvalid = 1'b0;
            end
        end
        @(negedge aclk);
        chk("b_early", bvalid, 0);
        @(negedge aclk);
        chk("b_latency", bvalid, 1);
        chk("b_regs", regs_out, model_packed());
        for (int i = 0; i < bdelay; i++) begin
            @(negedge aclk);
            chk("b_hold", {bvalid, awready, wready, bresp}, {3'b100, e});
        end
        @(posedge aclk); #1 bready = 1'b1;
        @(posedge aclk); #1 bready = 1'b0;
        @(negedge aclk);
        chk("w_idle_ready", {awready, wready, bvalid}, 3'b110);
        @(posedge aclk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < NREGS) return 32'(r * 4 + $urandom_range(0, 3));
        return $urandom;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; arvalid = 1'b0; rready = 1'b0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; awaddr = '0; wdata = '0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_outputs", {arready, awready, wready, rvalid, bvalid, bresp, rdata}, '0);
        chk("rst_regs", regs_out, model_packed());
        @(posedge aclk); #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_readies_pre", {arready, awready, wready}, 3'b000);
        @(negedge aclk);
        chk("rel_readies", {arready, awready, wready}, 3'b111);
        @(posedge aclk); #1;

        // Reset between handshake and commit abandons the write.
        awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'hAAAA_5555;
        wait_ready("abandon", 3);
        awvalid = 1'b0; wvalid = 1'b0; aresetn = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        chk("abandon_regs", regs_out, model_packed());
        chk("abandon_bvalid", bvalid, 0);
        @(posedge aclk); #1;

        do_write(32'h08, 32'hDEAD_BEEF, 0, 0, 0);
        do_read(32'h08, 0);
        do_write(32'h04, 32'h0000_1234, 2, 3, 0);
        do_read(32'h04, 5);
        do_write(32'h14, 32'hCAFE_F00D, 1, 2, 5);
        do_write(32'h40, 32'h1111_2222, 0, 0, 0);
        do_read(32'h40, 0);
        do_write(32'h00, 32'hFFFF_FFFF, 0, 0, 0);
        do_read(32'h00, 0);
`ifdef AXI4_LITE_REG_BANK_ID_EN
        chk("id_slot0", regs_out[31:0], ID_VAL);
`endif

        // Read captured on the commit edge returns the pre-write value.
        do_write(32'h0C, 32'h5555_AAAA, 0, 0, 0);
        rq.push_back(exp_read(32'h0C));
        bq.push_back(model_write(32'h0C, 32'h0BAD_F00D));
        awvalid = 1'b1; awaddr = 32'h0C; wvalid = 1'b1; wdata = 32'h0BAD_F00D;
        wait_ready("hazard_w", 3);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 32'h0C;
        @(negedge aclk);
        chk("hazard_arready", arready, 1);
        @(posedge aclk); #1 arvalid = 1'b0; rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        chk("hazard_both_valid", {rvalid, bvalid}, 2'b11);
        chk("hazard_regs", regs_out, model_packed());
        @(posedge aclk); #1 rready = 1'b0; bready = 1'b0;
        do_read(32'h0C, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), $urandom, $urandom_range(0, 2),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(rand_addr(), $urandom_range(0, 3));
        end

        repeat (2) @(negedge aclk);
        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        chk("final_regs", regs_out, model_packed());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
